// File: rtl/demux_l2_pkg.sv
// rtl/demux_l2_pkg.sv - shared constants and types for the layer-2 byte demux
package demux_l2_pkg;

  localparam int DATA_W_DEF       = 8;
  localparam int FLUSH_CYCLES_DEF = 4;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_HALF  = 1'b1
  } state_e;

  // Width of a counter that must hold 0..n inclusive.
  function automatic int cnt_w(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/demux_l2_if.sv
// rtl/demux_l2_if.sv - serial byte input and paired lane outputs of the layer-2 demux
interface demux_l2_if
  import demux_l2_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
);

  logic [DATA_W-1:0] dataIn;
  logic              validIn;
  logic [DATA_W-1:0] dataOut0;
  logic [DATA_W-1:0] dataOut1;
  logic              validOut0;
  logic              validOut1;
  logic              pending;

  modport master (
    output dataIn, validIn,
    input  dataOut0, dataOut1, validOut0, validOut1, pending
  );

  modport slave (
    input  dataIn, validIn,
    output dataOut0, dataOut1, validOut0, validOut1, pending
  );

endinterface

// File: rtl/demux_idle_timer.sv
// rtl/demux_idle_timer.sv - saturating idle counter used by the lone-byte flush (DEMUX_FLUSH_EN)
module demux_idle_timer
  import demux_l2_pkg::*;
#(
  parameter int MAX = FLUSH_CYCLES_DEF,
  parameter int W   = cnt_w(MAX)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != W'(MAX))) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/demux_l2.sv
// rtl/demux_l2.sv - layer-2 byte demux: pairs consecutive valid bytes onto two lanes
// Optional lone-byte flush after FLUSH_CYCLES idle cycles when DEMUX_FLUSH_EN is defined.
module demux_l2
  import demux_l2_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
`ifdef DEMUX_FLUSH_EN
  ,
  parameter int FLUSH_CYCLES = FLUSH_CYCLES_DEF
`endif
) (
  input  logic       clk,
  input  logic       reset,
  demux_l2_if.slave  bus
);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] hold0_q, hold0_d;
  logic [DATA_W-1:0] dout0_q, dout0_d;
  logic [DATA_W-1:0] dout1_q, dout1_d;
  logic              vout0_q, vout0_d;
  logic              vout1_q, vout1_d;
  logic              flush_now;

`ifdef DEMUX_FLUSH_EN
  localparam int CNT_W = cnt_w(FLUSH_CYCLES);

  logic [CNT_W-1:0] idle_cnt;

  // Counter is held clear outside HALF so every lone byte starts a fresh count.
  demux_idle_timer #(
    .MAX (FLUSH_CYCLES),
    .W   (CNT_W)
  ) u_idle_timer (
    .clk   (clk),
    .reset (reset),
    .clr_i (bus.validIn || (state_q != ST_HALF)),
    .inc_i ((state_q == ST_HALF) && !bus.validIn),
    .cnt_o (idle_cnt)
  );

  assign flush_now = (state_q == ST_HALF) && !bus.validIn &&
                     (idle_cnt == CNT_W'(FLUSH_CYCLES));
`else
  assign flush_now = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_EMPTY;
      hold0_q <= '0;
      dout0_q <= '0;
      dout1_q <= '0;
      vout0_q <= 1'b0;
      vout1_q <= 1'b0;
    end else begin
      state_q <= state_d;
      hold0_q <= hold0_d;
      dout0_q <= dout0_d;
      dout1_q <= dout1_d;
      vout0_q <= vout0_d;
      vout1_q <= vout1_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_EMPTY: if (bus.validIn) state_d = ST_HALF;
      ST_HALF:  if (bus.validIn || flush_now) state_d = ST_EMPTY;
      default:  state_d = ST_EMPTY;
    endcase
  end

  // A partner byte always wins over a flush that falls due in the same cycle.
  always_comb begin
    hold0_d = hold0_q;
    dout0_d = dout0_q;
    dout1_d = dout1_q;
    vout0_d = 1'b0;
    vout1_d = 1'b0;
    if (state_q == ST_EMPTY) begin
      if (bus.validIn) begin
        hold0_d = bus.dataIn;
      end
    end else if (bus.validIn) begin
      dout0_d = hold0_q;
      dout1_d = bus.dataIn;
      vout0_d = 1'b1;
      vout1_d = 1'b1;
    end else if (flush_now) begin
      dout0_d = hold0_q;
      vout0_d = 1'b1;
    end
  end

  assign bus.dataOut0  = dout0_q;
  assign bus.dataOut1  = dout1_q;
  assign bus.validOut0 = vout0_q;
  assign bus.validOut1 = vout1_q;
  assign bus.pending   = (state_q == ST_HALF);

endmodule

// File: tb/tb_demux_l2.sv
// tb/tb_demux_l2.sv - scoreboard bench for demux_l2 (flush cases under DEMUX_FLUSH_EN)
`timescale 1ns/1ps
module tb_demux_l2;
  import demux_l2_pkg::*;

  localparam int FLUSH_CYCLES = FLUSH_CYCLES_DEF;

  typedef struct {
    logic [7:0] d0;
    logic [7:0] d1;
    logic       v1;
    int         cyc;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;

  exp_t       expq[$];
  logic [7:0] pend[$];
  int         idle_run = 0;
  logic       exp_pending = 1'b0;
  logic [7:0] exp_last0 = 8'h00;
  logic [7:0] exp_last1 = 8'h00;

  demux_l2_if #(.DATA_W(8)) bus();

  demux_l2 dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic ok, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
  endtask

  // Reference: bytes queue up; every second one closes a pair, a lone byte left
  // idle for more than FLUSH_CYCLES cycles is flushed on lane 0 alone.
  task automatic step(input logic v, input logic [7:0] d);
    bus.validIn = v;
    bus.dataIn  = d;
    @(posedge clk);
    #1;
    if (v) begin
      pend.push_back(d);
      idle_run = 0;
      if (pend.size() == 2) begin
        expq.push_back('{d0: pend[0], d1: pend[1], v1: 1'b1, cyc: cyc});
        pend.delete();
      end
    end else if (pend.size() == 1) begin
      idle_run++;
`ifdef DEMUX_FLUSH_EN
      if (idle_run == FLUSH_CYCLES + 1) begin
        expq.push_back('{d0: pend[0], d1: 8'h00, v1: 1'b0, cyc: cyc});
        pend.delete();
      end
`endif
    end
    exp_pending = (pend.size() == 1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00);
  endtask

  task automatic apply_reset(input int n);
    reset = 1'b1;
    pend.delete();
    idle_run = 0;
    exp_pending = 1'b0;
    idle(n);
    reset = 1'b0;
  endtask

  // Monitor: compares every presented output against the scoreboard head.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk or posedge reset);
      if (reset) begin
        #1;
        check("reset_outputs",
              {bus.dataOut0, bus.dataOut1, bus.validOut0, bus.validOut1, bus.pending} == '0,
              {bus.dataOut0, bus.dataOut1, bus.validOut0, bus.validOut1, bus.pending}, 0);
        exp_last0 = 8'h00;
        exp_last1 = 8'h00;
        continue;
      end
      check("pending", bus.pending == exp_pending, bus.pending, exp_pending);
      if (bus.validOut0 || bus.validOut1) begin
        if (expq.size() == 0) begin
          check("unexpected_output", 1'b0, {bus.validOut0, bus.validOut1, bus.dataOut0, bus.dataOut1}, 0);
        end else begin
          e = expq.pop_front();
          check("valid_flags", {bus.validOut0, bus.validOut1} == {1'b1, e.v1},
                {bus.validOut0, bus.validOut1}, {1'b1, e.v1});
          check("lane0_data", bus.dataOut0 == e.d0, bus.dataOut0, e.d0);
          if (e.v1) begin
            check("lane1_data", bus.dataOut1 == e.d1, bus.dataOut1, e.d1);
            exp_last1 = e.d1;
          end else begin
            check("lane1_hold_on_flush", bus.dataOut1 == exp_last1, bus.dataOut1, exp_last1);
          end
          check("latency", cyc == e.cyc, cyc, e.cyc);
          exp_last0 = e.d0;
        end
      end else begin
        check("data_hold", {bus.dataOut0, bus.dataOut1} == {exp_last0, exp_last1},
              {bus.dataOut0, bus.dataOut1}, {exp_last0, exp_last1});
      end
    end
  end

  initial begin
    int run;
    bus.validIn = 1'b0;
    bus.dataIn  = 8'h00;
    apply_reset(3);

    step(1'b1, 8'hA1); step(1'b1, 8'hB2); idle(2);

    for (int i = 1; i <= 6; i++) step(1'b1, 8'(i));
    idle(2);

    step(1'b1, 8'hC3); idle(3); step(1'b1, 8'hD4); idle(2);

    step(1'b1, 8'hE5);
    apply_reset(2);
    step(1'b1, 8'h11); step(1'b1, 8'h22); idle(2);

`ifdef DEMUX_FLUSH_EN
    step(1'b1, 8'h77); idle(7);
    step(1'b1, 8'h88); idle(4); step(1'b1, 8'h99); idle(3);
`endif

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 15) == 0) begin
        run = $urandom_range(1, 8);
        idle(run);
      end else begin
        step($urandom_range(0, 3) != 0, 8'($urandom));
      end
    end
    idle(8);

    run = 0;
    while (expq.size() != 0 && run < 20) begin
      idle(1);
      run++;
    end
    check("drain", expq.size() == 0, expq.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
